contador_pasos: RTL and testbench

Micro-step sequencer for the control unit. It produces the 3-bit step index and disable signal that feed the 3-to-8 step decoder. The decoder turns them into the one-hot timing signals T0..T7. The sequencer walks T0 up to a per-instruction last step, supports early termination, pause and back-to-back instructions, and counts completed instructions.

---
 rtl/contador_pasos.sv | 100 ++++++++++
 tb/tb_contador_pasos.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/contador_pasos.sv
// Micro-step sequencer for the control unit: drives the step decoder (paso/dis),
// handles pause, early termination and back-to-back instructions, and counts completions.
module contador_pasos #(
    parameter int ANCHO_PASO   = 3,
    parameter int ANCHO_CUENTA = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inicio,
    input  logic                    continuo,
    input  logic                    pausa,
    input  logic                    fin_instr,
    input  logic [ANCHO_PASO-1:0]   num_pasos,
    output logic [ANCHO_PASO-1:0]   paso,
    output logic                    dis,
    output logic                    ocupado,
    output logic                    fin_ciclo,
    output logic [ANCHO_CUENTA-1:0] cuenta_instr
);

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        EJECUTA  = 2'd1,
        DETENIDO = 2'd2
    } estado_t;

    localparam logic [ANCHO_PASO-1:0]   PASO_UNO   = 1;
    localparam logic [ANCHO_CUENTA-1:0] CUENTA_UNO = 1;

    estado_t                 estado;
    logic [ANCHO_PASO-1:0]   ultimo;

    // Modulo-2^ANCHO_CUENTA increment; the natural overflow provides the wrap.
    function automatic logic [ANCHO_CUENTA-1:0] siguiente_cuenta(input logic [ANCHO_CUENTA-1:0] c);
        return c + CUENTA_UNO;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            estado       <= INACTIVO;
            paso         <= '0;
            dis          <= 1'b1;
            ocupado      <= 1'b0;
            fin_ciclo    <= 1'b0;
            cuenta_instr <= '0;
            ultimo       <= '0;
        end else begin
            fin_ciclo <= 1'b0;
            case (estado)
                INACTIVO: begin
                    paso <= '0;
                    if (inicio) begin
                        estado  <= EJECUTA;
                        dis     <= 1'b0;
                        ocupado <= 1'b1;
                        ultimo  <= num_pasos;
                    end else begin
                        dis     <= 1'b1;
                        ocupado <= 1'b0;
                    end
                end
                EJECUTA: begin
                    // Pause beats early end: a fin_instr seen together with pausa is dropped.
                    if (pausa) begin
                        estado <= DETENIDO;
                        dis    <= 1'b1;
                    end else if (fin_instr || (paso == ultimo)) begin
                        fin_ciclo    <= 1'b1;
                        cuenta_instr <= siguiente_cuenta(cuenta_instr);
                        paso         <= '0;
                        if (continuo) begin
                            ultimo <= num_pasos;
                            dis    <= 1'b0;
                        end else begin
                            estado  <= INACTIVO;
                            dis     <= 1'b1;
                            ocupado <= 1'b0;
                        end
                    end else begin
                        paso <= paso + PASO_UNO;
                    end
                end
                DETENIDO: begin
                    // Resume re-issues the held step for a full cycle before advancing.
                    if (!pausa) begin
                        estado <= EJECUTA;
                        dis    <= 1'b0;
                    end
                end
                default: begin
                    estado  <= INACTIVO;
                    paso    <= '0;
                    dis     <= 1'b1;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_contador_pasos.sv
// Bench for contador_pasos: vector table, hand-written multi-cycle sequences,
// and randomized stimulus against a step-level reference model.
module tb_contador_pasos;

    logic       clk = 1'b0;
    logic       rst, inicio, continuo, pausa, fin_instr;
    logic [2:0] num_pasos;
    logic [2:0] paso;
    logic       dis, ocupado, fin_ciclo;
    logic [7:0] cuenta_instr;

    int n_tests = 0;
    int n_fail  = 0;

    contador_pasos #(.ANCHO_PASO(3), .ANCHO_CUENTA(8)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .continuo(continuo),
        .pausa(pausa), .fin_instr(fin_instr), .num_pasos(num_pasos),
        .paso(paso), .dis(dis), .ocupado(ocupado), .fin_ciclo(fin_ciclo),
        .cuenta_instr(cuenta_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, inicio, continuo, pausa, fin_instr;
        logic [2:0] num;
        logic [2:0] e_paso;
        logic       e_dis, e_ocu, e_fin;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tabla[$];

    task automatic add(input logic r, input logic i, input logic c, input logic p, input logic f,
                       input logic [2:0] n, input logic [2:0] ep, input logic ed, input logic eo,
                       input logic ef, input logic [7:0] ec);
        vec_t v;
        v.rst = r; v.inicio = i; v.continuo = c; v.pausa = p; v.fin_instr = f; v.num = n;
        v.e_paso = ep; v.e_dis = ed; v.e_ocu = eo; v.e_fin = ef; v.e_cnt = ec;
        tabla.push_back(v);
    endtask

    task automatic drive(input logic r, input logic i, input logic c, input logic p, input logic f,
                         input logic [2:0] n);
        rst = r; inicio = i; continuo = c; pausa = p; fin_instr = f; num_pasos = n;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] ep, input logic ed, input logic eo,
                       input logic ef, input logic [7:0] ec);
        n_tests++;
        if (paso !== ep || dis !== ed || ocupado !== eo || fin_ciclo !== ef || cuenta_instr !== ec) begin
            n_fail++;
            $display("FAIL %s: got paso=%0d dis=%0b ocupado=%0b fin_ciclo=%0b cuenta=%0d, want paso=%0d dis=%0b ocupado=%0b fin_ciclo=%0b cuenta=%0d",
                     name, paso, dis, ocupado, fin_ciclo, cuenta_instr, ep, ed, eo, ef, ec);
        end
    endtask

    // Reference model: instruction-level view (busy / held / current step / last step).
    bit m_busy, m_held, m_pulse;
    int m_step, m_last, m_count;

    task automatic model_step();
        m_pulse = 0;
        if (rst) begin
            m_busy = 0; m_held = 0; m_step = 0; m_last = 0; m_count = 0;
        end else if (!m_busy) begin
            m_step = 0;
            if (inicio) begin
                m_busy = 1; m_last = int'(num_pasos);
            end
        end else if (m_held) begin
            if (!pausa) m_held = 0;
        end else if (pausa) begin
            m_held = 1;
        end else if (fin_instr || m_step == m_last) begin
            m_pulse = 1;
            m_count = (m_count + 1) % 256;
            m_step = 0;
            if (continuo) m_last = int'(num_pasos);
            else m_busy = 0;
        end else begin
            m_step = m_step + 1;
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);

        // rst inicio cont pausa fin num | paso dis ocu fin cnt
        add(1,0,0,0,0,0, 0,1,0,0,0);
        add(0,1,0,0,0,3, 0,0,1,0,0);
        add(0,0,0,0,0,0, 1,0,1,0,0);
        add(0,0,0,0,0,0, 2,0,1,0,0);
        add(0,0,0,0,0,0, 3,0,1,0,0);
        add(0,0,0,0,0,0, 0,1,0,1,1);
        add(0,0,0,0,0,0, 0,1,0,0,1);
        add(0,1,0,0,0,5, 0,0,1,0,1);
        add(0,0,0,0,0,0, 1,0,1,0,1);
        add(0,0,0,0,0,0, 2,0,1,0,1);
        add(0,0,0,0,0,0, 3,0,1,0,1);
        add(0,0,0,0,0,0, 4,0,1,0,1);
        add(0,0,0,1,0,0, 4,1,1,0,1);
        add(0,0,0,1,1,0, 4,1,1,0,1);
        add(0,0,0,1,0,0, 4,1,1,0,1);
        add(0,0,0,0,0,0, 4,0,1,0,1);
        add(0,0,0,0,0,0, 5,0,1,0,1);
        add(0,0,0,0,0,0, 0,1,0,1,2);
        add(0,1,0,0,0,5, 0,0,1,0,2);
        add(0,0,0,0,0,0, 1,0,1,0,2);
        add(0,0,0,0,0,0, 2,0,1,0,2);
        add(0,0,0,0,1,0, 0,1,0,1,3);
        add(0,1,0,0,0,7, 0,0,1,0,3);
        add(0,1,0,0,0,7, 1,0,1,0,3);
        add(0,1,0,0,0,7, 2,0,1,0,3);
        add(1,1,0,0,0,7, 0,1,0,0,0);
        add(0,0,0,0,0,0, 0,1,0,0,0);
        add(0,1,0,0,0,0, 0,0,1,0,0);
        add(0,0,0,0,0,0, 0,1,0,1,1);
        add(0,0,0,0,0,0, 0,1,0,0,1);
        add(0,1,0,0,0,1, 0,0,1,0,1);
        add(0,0,0,0,0,0, 1,0,1,0,1);
        add(0,0,0,0,1,0, 0,1,0,1,2);
        add(0,0,0,0,0,0, 0,1,0,0,2);
        add(0,0,0,1,1,0, 0,1,0,0,2);

        for (int k = 0; k < tabla.size(); k++) begin
            drive(tabla[k].rst, tabla[k].inicio, tabla[k].continuo, tabla[k].pausa,
                  tabla[k].fin_instr, tabla[k].num);
            tick();
            chk($sformatf("vec%0d", k), tabla[k].e_paso, tabla[k].e_dis, tabla[k].e_ocu,
                tabla[k].e_fin, tabla[k].e_cnt);
        end

        // Back-to-back 8-step instructions, then a reload to a 2-step instruction.
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0, 7); tick();
        chk("b2b_start", 0, 0, 1, 0, 0);
        inicio = 0;
        for (int k = 1; k <= 7; k++) begin tick(); chk($sformatf("b2b_a%0d", k), 3'(k), 0, 1, 0, 0); end
        tick(); chk("b2b_end1", 0, 0, 1, 1, 1);
        for (int k = 1; k <= 7; k++) begin tick(); chk($sformatf("b2b_b%0d", k), 3'(k), 0, 1, 0, 1); end
        num_pasos = 1;
        tick(); chk("b2b_end2", 0, 0, 1, 1, 2);
        num_pasos = 5;
        tick(); chk("b2b_c1", 1, 0, 1, 0, 2);
        continuo = 0;
        tick(); chk("b2b_end3", 0, 1, 0, 1, 3);

        // Counter wrap with single-step instructions.
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0, 0); tick();
        chk("wrap_start", 0, 0, 1, 0, 0);
        inicio = 0;
        for (int k = 1; k <= 255; k++) tick();
        chk("wrap_255", 0, 0, 1, 1, 255);
        continuo = 0;
        tick(); chk("wrap_0", 0, 1, 0, 1, 0);
        tick(); chk("wrap_idle", 0, 1, 0, 0, 0);

        // Randomized run against the model.
        drive(1, 0, 0, 0, 0, 0); model_step(); tick();
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)));
            model_step();
            tick();
            chk($sformatf("rnd%0d", k), 3'(m_step), !(m_busy && !m_held), m_busy, m_pulse, 8'(m_count));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
